// File: rtl/k2red_inv_pipe.sv
// k2red_inv_pipe: removes the K2-RED scaling factor, out = a * 169^-1 mod 3329
// (a * 2285 mod 3329). Three registered stages with a valid/ready stream on
// both sides; a bubble anywhere in the pipe is filled even while the output
// is stalled.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   upstream beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   in_data    coefficient a (12 bits; values >= Q are reduced, never wrapped)
//   in_tag     sideband tag, travels with its beat
//   out_valid  out_data/out_tag valid
//   out_ready  downstream accepts a beat
//   out_data   a*KINV mod Q, always 0..Q-1
//   out_tag    tag of the delivered beat
//   range_err  sticky flag for an accepted in_data >= Q
//              (only when K2INV_RANGE_CHK_EN is defined)
//
// Build option: define K2INV_RANGE_CHK_EN to add the range_err port and logic.
module k2red_inv_pipe #(
    parameter int unsigned DW = 12,
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [TW-1:0] out_tag
`ifdef K2INV_RANGE_CHK_EN
    ,
    output logic          range_err
`endif
);

    localparam int unsigned Q    = 3329;
    localparam int unsigned KINV = 2285;
    localparam int unsigned PW   = DW + 12;   // full product width, covers a up to 2^DW-1
    localparam int unsigned BW   = 13;        // Barrett multiplier width
    localparam int unsigned BS   = 24;        // Barrett shift
    localparam int unsigned MW   = PW + BW;
    localparam int unsigned QW   = 13;        // quotient estimate width
    localparam int unsigned RW   = 14;        // partial remainder width (< 3Q)

    localparam logic [DW-1:0] Q_D    = DW'(Q);
    localparam logic [PW-1:0] KINV_P = PW'(KINV);
    localparam logic [PW-1:0] Q_P    = PW'(Q);
    localparam logic [BW-1:0] BM     = BW'(5039);   // floor(2^24 / 3329)
    localparam logic [RW-1:0] Q_R    = RW'(Q);
    localparam logic [RW-1:0] Q2_R   = RW'(2 * Q);

    logic          v1, v2;
    logic [DW-1:0] a1;
    logic [TW-1:0] t1, t2;
    logic [PW-1:0] p2;
    logic          adv1, adv2, adv3;

    logic [MW-1:0] bprod;
    logic [QW-1:0] qest;
    logic [RW-1:0] r0, r1;

    // Stage advance chain: a stage moves when it is empty or its successor moves.
    assign adv3     = ~out_valid | out_ready;
    assign adv2     = ~v2 | adv3;
    assign adv1     = ~v1 | adv2;
    assign in_ready = adv1;

    // Barrett reduction of p2: quotient may be low by up to 2, fixed by two compares.
    always_comb begin
        bprod = MW'(p2) * MW'(BM);
        qest  = QW'(bprod >> BS);
        r0    = RW'(p2 - PW'(qest) * Q_P);
        r1    = r0;
        if (r0 >= Q2_R) begin
            r1 = r0 - Q2_R;
        end else if (r0 >= Q_R) begin
            r1 = r0 - Q_R;
        end
    end

    // S1: capture coefficient and tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            t1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1 <= in_data;
                t1 <= in_tag;
            end
        end
    end

    // S2: full-width product a*KINV.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2 <= 1'b0;
            p2 <= '0;
            t2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                p2 <= PW'(a1) * KINV_P;
                t2 <= t1;
            end
        end
    end

    // S3: fully reduced result, drives the output port registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (adv3) begin
            out_valid <= v2;
            if (v2) begin
                out_data <= DW'(r1);
                out_tag  <= t2;
            end
        end
    end

`ifdef K2INV_RANGE_CHK_EN
    // Sticky out-of-range flag, set by any accepted beat with a >= Q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            range_err <= 1'b0;
        end else if (in_valid && in_ready && (in_data >= Q_D)) begin
            range_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_k2red_inv_pipe.sv
module tb_k2red_inv_pipe;

    localparam int Q    = 3329;
    localparam int KINV = 2285;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [11:0] in_data, out_data;
    logic [3:0]  in_tag, out_tag;
`ifdef K2INV_RANGE_CHK_EN
    logic        range_err;
`endif

    k2red_inv_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef K2INV_RANGE_CHK_EN
        ,
        .range_err (range_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int tag;
        int acc;
    } beat_t;

    typedef struct {
        int a;
        int tag;
        int exp;
    } vec_t;

    beat_t sb[$];              // beats accepted but not yet delivered, in order
    int    checks     = 0;
    int    errors     = 0;
    int    cyc        = 0;
    int    del_cnt    = 0;
    int    acc_cnt    = 0;
    int    stall_cnt  = 0;
    int    last_data  = 0;
    bit    lat_chk    = 1'b0;
    bit    model_rerr = 1'b0;

    function automatic int kinv(input int a);
        return (a * KINV) % Q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input bit iv, input int d, input int t, input bit ordy);
        beat_t b;
        in_valid  = iv;
        in_data   = 12'(d);
        in_tag    = 4'(t);
        out_ready = ordy;
        #1;
        check("in_ready", int'(in_ready), (sb.size() == 3 && !ordy) ? 0 : 1);
        if (sb.size() == 3) check("out_valid_when_full", int'(out_valid), 1);
        if (!in_ready) stall_cnt++;
`ifdef K2INV_RANGE_CHK_EN
        check("range_err", int'(range_err), int'(model_rerr));
`endif
        if (out_valid && out_ready) begin
            check("beat_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                b = sb.pop_front();
                check("out_data", int'(out_data), kinv(b.a));
                check("out_tag", int'(out_tag), b.tag);
                check("k2red_roundtrip", (int'(out_data) * 169) % Q, b.a % Q);
                if (lat_chk) check("latency", cyc - b.acc, 3);
            end
            del_cnt++;
            last_data = int'(out_data);
        end
        if (in_valid && in_ready) begin
            b.a   = int'(in_data);
            b.tag = int'(in_tag);
            b.acc = cyc;
            sb.push_back(b);
            acc_cnt++;
            if (int'(in_data) >= Q) model_rerr = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            cycle(1'b0, 0, 0, 1'b1);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_tag", int'(out_tag), 0);
`ifdef K2INV_RANGE_CHK_EN
        check("rst_range_err", int'(range_err), 0);
`endif
        sb.delete();
        model_rerr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        int base, c0, n;
        bit ordy;

        vecs[0] = '{a: 1,    tag: 1, exp: 2285};
        vecs[1] = '{a: 169,  tag: 2, exp: 1};
        vecs[2] = '{a: 0,    tag: 3, exp: 0};
        vecs[3] = '{a: 3328, tag: 4, exp: 1044};
        vecs[4] = '{a: 4000, tag: 5, exp: 1895};
        vecs[5] = '{a: 4095, tag: 6, exp: 2585};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Single beats from the table, each checked for value and 3-cycle latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            base = del_cnt;
            cycle(1'b1, vecs[i].a, vecs[i].tag, 1'b1);
            n = 0;
            while (del_cnt == base && n < 8) begin
                cycle(1'b0, 0, 0, 1'b1);
                n++;
            end
            check("vec_delivered", del_cnt - base, 1);
            check("vec_data", last_data, vecs[i].exp);
        end

        // Full sweep back-to-back: one beat per cycle, fixed latency.
        c0   = cyc;
        base = del_cnt;
        for (int a = 0; a < Q; a++) cycle(1'b1, a, a & 15, 1'b1);
        drain("sweep_drain");
        check("sweep_count", del_cnt - base, Q);
        check("sweep_cycles", cyc - c0, Q + 3);
        lat_chk = 1'b0;

        // Six beats with a 5-cycle output stall in the middle.
        base      = acc_cnt;
        c0        = del_cnt;
        stall_cnt = 0;
        n         = 0;
        while ((acc_cnt - base < 6 || sb.size() != 0) && n < 40) begin
            ordy = !(n >= 3 && n < 8);
            cycle(acc_cnt - base < 6, $urandom_range(0, Q - 1), n, ordy);
            n++;
        end
        check("stall_accepted", acc_cnt - base, 6);
        check("stall_delivered", del_cnt - c0, 6);
        check("stall_in_ready_low_cycles", stall_cnt, 5);

        // out_ready toggling with in_valid held: one delivery per ready cycle once full.
        for (int i = 0; i < 40; i++) begin
            base = del_cnt;
            cycle(1'b1, $urandom_range(0, Q - 1), i, (i % 2) == 0);
            if (i >= 6 && (i % 2) == 0) check("toggle_one_per_ready", del_cnt - base, 1);
        end
        drain("toggle_drain");

        // Random traffic, full 12-bit input range.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4095),
                  $urandom_range(0, 15), $urandom_range(0, 9) < 7);
        end
        drain("random_drain");

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 100 + i, i, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b1);
        base = del_cnt;
        cycle(1'b1, 2, 7, 1'b1);
        n = 0;
        while (del_cnt == base && n < 8) begin
            cycle(1'b0, 0, 0, 1'b1);
            n++;
        end
        check("post_reset_delivered", del_cnt - base, 1);
        check("post_reset_data", last_data, 1241);

`ifdef K2INV_RANGE_CHK_EN
        // Sticky range flag survives legal traffic and clears only on reset.
        do_reset();
        cycle(1'b1, 4000, 1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, $urandom_range(0, Q - 1), i, 1'b1);
        drain("range_drain");
        check("range_err_sticky", int'(range_err), 1);
        do_reset();
        cycle(1'b0, 0, 0, 1'b1);
        check("range_err_cleared", int'(range_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
